// File: rtl/dmem_wb_bridge_pkg.sv
// Shared configuration and FSM encoding for the data-memory to Wishbone bridge.
package dmem_wb_bridge_pkg;

    localparam int unsigned DefaultRw        = 16;
    localparam int unsigned DefaultAddrBytes = 2;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBus  = 2'd1,
        StResp = 2'd2
    } bridge_state_e;

endpackage

// File: rtl/dmem_wb_bridge_if.sv
// Core memory port plus Wishbone master bus, grouped; master is the bridge's view.
interface dmem_wb_bridge_if
    import dmem_wb_bridge_pkg::*;
#(
    parameter int unsigned RW    = DefaultRw,
    parameter int unsigned SEL_W = DefaultAddrBytes
);

    logic             i_mem_req;
    logic             i_mem_we;
    logic [RW-1:0]    i_mem_addr;
    logic [RW-1:0]    i_mem_data;
    logic [SEL_W-1:0] i_mem_sel;
    logic             i_data_page;
    logic [RW-1:0]    o_mem_data;
    logic             o_mem_ack;
    logic             o_mem_exception;

    logic             wb_cyc;
    logic             wb_stb;
    logic             wb_we;
    logic [RW:0]      wb_adr;
    logic [RW-1:0]    wb_o_dat;
    logic [SEL_W-1:0] wb_sel;
    logic [RW-1:0]    wb_i_dat;
    logic             wb_ack;
    logic             wb_err;

    modport master (
        input  i_mem_req, i_mem_we, i_mem_addr, i_mem_data, i_mem_sel, i_data_page,
        output o_mem_data, o_mem_ack, o_mem_exception,
        output wb_cyc, wb_stb, wb_we, wb_adr, wb_o_dat, wb_sel,
        input  wb_i_dat, wb_ack, wb_err
    );

    modport slave (
        output i_mem_req, i_mem_we, i_mem_addr, i_mem_data, i_mem_sel, i_data_page,
        input  o_mem_data, o_mem_ack, o_mem_exception,
        input  wb_cyc, wb_stb, wb_we, wb_adr, wb_o_dat, wb_sel,
        output wb_i_dat, wb_ack, wb_err
    );

endinterface

// File: rtl/dmem_wb_bridge_bus_timeout_ctr.sv
// BUS-state cycle counter; o_hit flags the TimeoutCyc-th consecutive BUS cycle.
module bus_timeout_ctr #(
    parameter int unsigned TimeoutCyc = 255
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_en,
    output logic o_hit
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clear) begin
            cnt_d = '0;
        end else if (i_en) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // cnt_q is 0 in the first BUS cycle, so TimeoutCyc-1 marks the last allowed one.
    assign o_hit = i_en && (cnt_q == 8'(TimeoutCyc - 1));

endmodule

// File: rtl/dmem_wb_bridge.sv
// Core req/ack to single-transfer Wishbone master bridge.
// Optional bus timeout enabled by defining DMEM_BRIDGE_TIMEOUT_EN.
module dmem_wb_bridge
    import dmem_wb_bridge_pkg::*;
#(
    parameter int unsigned RW          = DefaultRw,
    parameter int unsigned SEL_W       = DefaultAddrBytes,
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic             i_clk,
    input  logic             i_rst,
    dmem_wb_bridge_if.master bus_io
);

    bridge_state_e    state_q, state_d;
    logic             we_q, we_d;
    logic [RW:0]      adr_q, adr_d;
    logic [RW-1:0]    dat_q, dat_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [RW-1:0]    rdata_q, rdata_d;
    logic             exc_q, exc_d;
    logic             start;
    logic             timeout_hit;

    assign start = (state_q == StIdle) && bus_io.i_mem_req;

`ifdef DMEM_BRIDGE_TIMEOUT_EN
    bus_timeout_ctr #(
        .TimeoutCyc(TIMEOUT_CYC)
    ) u_timeout (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clear(start),
        .i_en   (state_q == StBus),
        .o_hit  (timeout_hit)
    );
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYC;
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (bus_io.i_mem_req) state_d = StBus;
            StBus:   if (bus_io.wb_ack || bus_io.wb_err || timeout_hit) state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        rdata_d = rdata_q;
        exc_d   = exc_q;
        if (start) begin
            we_d  = bus_io.i_mem_we;
            adr_d = {bus_io.i_data_page, bus_io.i_mem_addr};
            dat_d = bus_io.i_mem_data;
            sel_d = bus_io.i_mem_sel;
        end
        // Error beats ack; a timeout only counts when the slave stayed silent.
        if (state_q == StBus) begin
            if (bus_io.wb_err || (timeout_hit && !bus_io.wb_ack)) begin
                rdata_d = '0;
                exc_d   = 1'b1;
            end else if (bus_io.wb_ack) begin
                rdata_d = we_q ? '0 : bus_io.wb_i_dat;
                exc_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
            exc_q   <= 1'b0;
        end else begin
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            rdata_q <= rdata_d;
            exc_q   <= exc_d;
        end
    end

    always_comb begin
        bus_io.wb_cyc          = (state_q == StBus);
        bus_io.wb_stb          = (state_q == StBus);
        bus_io.wb_we           = we_q;
        bus_io.wb_adr          = adr_q;
        bus_io.wb_o_dat        = dat_q;
        bus_io.wb_sel          = sel_q;
        bus_io.o_mem_ack       = (state_q == StResp);
        bus_io.o_mem_exception = (state_q == StResp) && exc_q;
        bus_io.o_mem_data      = (state_q == StResp) ? rdata_q : '0;
    end

endmodule

// File: tb/tb_dmem_wb_bridge.sv
// Directed self-checking bench for dmem_wb_bridge.
module tb_dmem_wb_bridge;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;

    dmem_wb_bridge_if #(.RW(16), .SEL_W(2)) bus ();

    dmem_wb_bridge #(
        .RW         (16),
        .SEL_W      (2),
        .TIMEOUT_CYC(8)
    ) dut (
        .i_clk (clk),
        .i_rst (rst_n),
        .bus_io(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transfer; slave responds in the (waits+1)-th BUS cycle.
    task automatic xfer(input string tag, input logic we, input logic [15:0] addr,
                        input logic page, input logic [15:0] wdat, input logic [1:0] sel,
                        input int waits, input logic err, input logic [15:0] rdat,
                        input logic [15:0] exp_rdata);
        bus.i_mem_req   = 1'b1;
        bus.i_mem_we    = we;
        bus.i_mem_addr  = addr;
        bus.i_data_page = page;
        bus.i_mem_data  = wdat;
        bus.i_mem_sel   = sel;
        tick();
        bus.i_mem_addr  = ~addr;
        bus.i_mem_data  = ~wdat;
        bus.i_mem_we    = ~we;
        for (int i = 0; i <= waits; i++) begin
            check({tag, ".cyc"}, {31'd0, bus.wb_cyc}, 32'd1);
            check({tag, ".stb"}, {31'd0, bus.wb_stb}, 32'd1);
            check({tag, ".we"}, {31'd0, bus.wb_we}, {31'd0, we});
            check({tag, ".adr"}, {15'd0, bus.wb_adr}, {15'd0, page, addr});
            check({tag, ".odat"}, {16'd0, bus.wb_o_dat}, {16'd0, wdat});
            check({tag, ".sel"}, {30'd0, bus.wb_sel}, {30'd0, sel});
            check({tag, ".early_ack"}, {31'd0, bus.o_mem_ack}, 32'd0);
            if (i == waits) begin
                bus.wb_ack   = 1'b1;
                bus.wb_err   = err;
                bus.wb_i_dat = rdat;
            end
            tick();
        end
        bus.wb_ack    = 1'b0;
        bus.wb_err    = 1'b0;
        bus.wb_i_dat  = 16'h5A5A;
        bus.i_mem_req = 1'b0;
        check({tag, ".ack"}, {31'd0, bus.o_mem_ack}, 32'd1);
        check({tag, ".exc"}, {31'd0, bus.o_mem_exception}, {31'd0, err});
        check({tag, ".rdata"}, {16'd0, bus.o_mem_data}, {16'd0, exp_rdata});
        check({tag, ".cyc_drop"}, {31'd0, bus.wb_cyc}, 32'd0);
        tick();
        check({tag, ".ack_end"}, {31'd0, bus.o_mem_ack}, 32'd0);
        check({tag, ".exc_end"}, {31'd0, bus.o_mem_exception}, 32'd0);
        check({tag, ".idle_cyc"}, {31'd0, bus.wb_cyc}, 32'd0);
    endtask

    initial begin
        n_checks        = 0;
        n_pass          = 0;
        rst_n           = 1'b0;
        bus.i_mem_req   = 1'b0;
        bus.i_mem_we    = 1'b0;
        bus.i_mem_addr  = '0;
        bus.i_mem_data  = '0;
        bus.i_mem_sel   = '0;
        bus.i_data_page = 1'b0;
        bus.wb_i_dat    = '0;
        bus.wb_ack      = 1'b0;
        bus.wb_err      = 1'b0;
        tick();
        tick();
        check("rst.cyc", {31'd0, bus.wb_cyc}, 32'd0);
        check("rst.stb", {31'd0, bus.wb_stb}, 32'd0);
        check("rst.we", {31'd0, bus.wb_we}, 32'd0);
        check("rst.adr", {15'd0, bus.wb_adr}, 32'd0);
        check("rst.odat", {16'd0, bus.wb_o_dat}, 32'd0);
        check("rst.sel", {30'd0, bus.wb_sel}, 32'd0);
        check("rst.ack", {31'd0, bus.o_mem_ack}, 32'd0);
        check("rst.exc", {31'd0, bus.o_mem_exception}, 32'd0);
        check("rst.rdata", {16'd0, bus.o_mem_data}, 32'd0);
        rst_n = 1'b1;
        tick();

        xfer("rd0", 1'b0, 16'h1234, 1'b1, 16'h0000, 2'b11, 0, 1'b0, 16'hBEEF, 16'hBEEF);
        check("rd0.adr_full", {15'd0, bus.wb_adr}, 32'h0001_1234);
        xfer("wr3", 1'b1, 16'h0042, 1'b0, 16'h00A5, 2'b01, 3, 1'b0, 16'hFFFF, 16'h0000);
        xfer("err", 1'b0, 16'h0100, 1'b1, 16'h0000, 2'b10, 1, 1'b1, 16'hCAFE, 16'h0000);

        // Stray ack while idle must not start or complete anything.
        bus.wb_ack   = 1'b1;
        bus.wb_i_dat = 16'h7777;
        tick();
        bus.wb_ack   = 1'b0;
        check("stray.ack", {31'd0, bus.o_mem_ack}, 32'd0);
        check("stray.cyc", {31'd0, bus.wb_cyc}, 32'd0);
        xfer("b2b_a", 1'b0, 16'h0AAA, 1'b0, 16'h0000, 2'b11, 0, 1'b0, 16'h1111, 16'h1111);
        xfer("b2b_b", 1'b1, 16'h0BBB, 1'b1, 16'h2222, 2'b11, 0, 1'b0, 16'h3333, 16'h0000);
        check("b2b.no_dup", {31'd0, bus.wb_cyc}, 32'd0);

        bus.i_mem_req   = 1'b1;
        bus.i_mem_we    = 1'b1;
        bus.i_mem_addr  = 16'h0F0F;
        bus.i_data_page = 1'b0;
        bus.i_mem_data  = 16'h1111;
        bus.i_mem_sel   = 2'b10;
        tick();
        check("mid.cyc_before", {31'd0, bus.wb_cyc}, 32'd1);
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("mid.cyc_async", {31'd0, bus.wb_cyc}, 32'd0);
        check("mid.stb_async", {31'd0, bus.wb_stb}, 32'd0);
        check("mid.adr_async", {15'd0, bus.wb_adr}, 32'd0);
        bus.i_mem_req = 1'b0;
        tick();
        check("mid.ack", {31'd0, bus.o_mem_ack}, 32'd0);
        check("mid.exc", {31'd0, bus.o_mem_exception}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("mid.idle", {31'd0, bus.wb_cyc}, 32'd0);
        xfer("post_rst", 1'b0, 16'h4321, 1'b1, 16'h0000, 2'b01, 2, 1'b0, 16'h9876, 16'h9876);

`ifdef DMEM_BRIDGE_TIMEOUT_EN
        bus.i_mem_req   = 1'b1;
        bus.i_mem_we    = 1'b0;
        bus.i_mem_addr  = 16'h0ABC;
        bus.i_data_page = 1'b0;
        bus.i_mem_sel   = 2'b11;
        tick();
        bus.i_mem_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check("to.cyc", {31'd0, bus.wb_cyc}, 32'd1);
            check("to.early_ack", {31'd0, bus.o_mem_ack}, 32'd0);
            tick();
        end
        check("to.ack", {31'd0, bus.o_mem_ack}, 32'd1);
        check("to.exc", {31'd0, bus.o_mem_exception}, 32'd1);
        check("to.rdata", {16'd0, bus.o_mem_data}, 32'd0);
        check("to.cyc_drop", {31'd0, bus.wb_cyc}, 32'd0);
        tick();
        check("to.ack_end", {31'd0, bus.o_mem_ack}, 32'd0);
        xfer("to_edge", 1'b0, 16'h0DEF, 1'b1, 16'h0000, 2'b11, 7, 1'b0, 16'h1357, 16'h1357);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_wb_bridge.md
Name: dmem_wb_bridge

Overview:
- Sits directly downstream of the core's data-memory port (MEM&WB stage).
- Converts the core's req/ack memory handshake into a classic single-transfer Wishbone master cycle.
- Registers each request, drives the bus until the slave responds, then returns read data, ack and a bus-error/exception indication to the core.
- One outstanding transfer at a time; no pipelining on the bus side.

Parameters:
- RW, 16, data/address word width (matches `RW).
- SEL_W, 2, byte-select width (matches `ADDR_BYTES).
- TIMEOUT_CYC, 255, bus cycles in BUS state before forced error (used only with the optional feature).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, asynchronous, active-low.
- i_mem_req  in  1  core request; held high with stable addr/data/we/sel until o_mem_ack.
- i_mem_we  in  1  1 = write.
- i_mem_addr  in  RW  word address.
- i_mem_data  in  RW  write data.
- i_mem_sel  in  SEL_W  byte lanes.
- i_data_page  in  1  core data-page bit; prepended to the bus address.
- o_mem_data  out  RW  read data; valid only while o_mem_ack=1.
- o_mem_ack  out  1  one-cycle completion pulse.
- o_mem_exception  out  1  one-cycle pulse coincident with o_mem_ack on error.
- wb_cyc  out  1  Wishbone cycle.
- wb_stb  out  1  Wishbone strobe.
- wb_we  out  1  Wishbone write enable.
- wb_adr  out  RW+1  Wishbone address, {page, addr}.
- wb_o_dat  out  RW  Wishbone write data.
- wb_sel  out  SEL_W  Wishbone byte select.
- wb_i_dat  in  RW  Wishbone read data.
- wb_ack  in  1  Wishbone slave ack.
- wb_err  in  1  Wishbone slave error.

Behaviour:
- Reset (i_rst=0, async): state IDLE. All outputs 0: cyc, stb, we, adr, o_dat, sel, o_mem_ack, o_mem_exception, o_mem_data.
- States: IDLE, BUS, RESP.
- IDLE & i_mem_req:
  - Latch we/{page,addr}/data/sel into bus registers.
  - Set cyc=stb=1.
  - Go to BUS.
- BUS, wb_ack=1:
  - Capture wb_i_dat (reads; writes capture 0) into o_mem_data.
  - Drop cyc/stb; set o_mem_ack=1; go to RESP.
- BUS, wb_err=1:
  - Same as wb_ack, but o_mem_data=0 and o_mem_exception=1.
  - wb_err takes priority if wb_ack and wb_err are asserted together.
- BUS, neither: hold all bus outputs stable.
- RESP: o_mem_ack and o_mem_exception high for exactly this cycle; unconditionally go to IDLE.
- Core drops or replaces i_mem_req at the same edge it samples ack, so IDLE never re-issues a completed request.
- Latency: req sampled at edge 0 → cyc/stb high in cycle 1 → slave ack in cycle k (k≥1) → o_mem_ack in cycle k+1.
  - Minimum 2 cycles req→ack; throughput 1 transfer per 3 cycles.
- wb_ack/wb_err outside BUS are ignored.
- i_mem_req changes while in BUS/RESP are ignored; latched values are used.
- Reset mid-transfer drops cyc/stb immediately (async); no ack or exception is generated.

Optional Feature:
- Macro: DMEM_BRIDGE_TIMEOUT_EN.
- Defined:
  - 8-bit counter cleared on IDLE→BUS, incremented each BUS cycle.
  - Reaching TIMEOUT_CYC without ack/err is treated exactly as wb_err: exception pulse, data 0, cyc dropped.
  - Slave ack arriving on the same cycle the count hits TIMEOUT_CYC wins, i.e. a normal ack.
- Undefined: no counter; BUS waits indefinitely.

Decomposition:
- Shared package/config: state encoding constants (ST_IDLE=0, ST_BUS=1, ST_RESP=2), `RW, `ADDR_BYTES.
- Optional sub-module bus_timeout_ctr (counter plus compare) instantiated only under DMEM_BRIDGE_TIMEOUT_EN.
- Everything else is a single flat FSM.

Test Plan:
- Read, zero-wait slave:
  - Stimulus: addr=0x1234, page=1, sel=2'b11, slave acks the first cycle stb is seen with 0xBEEF.
  - Required: wb_adr=0x11234, cyc/stb high for 1 cycle, o_mem_ack pulse 2 cycles after req, o_mem_data=0xBEEF, exception 0.
- Write, 3 wait states:
  - Stimulus: data=0x00A5, sel=2'b01.
  - Required: wb_we=1, wb_o_dat/sel stable for 4 cycles, single ack pulse, no exception.
- Error:
  - Stimulus: slave asserts wb_err and wb_ack together.
  - Required: ack+exception pulse together, o_mem_data=0.
- Back-to-back:
  - Stimulus: core reissues a new req the cycle after ack.
  - Required: second cyc starts one cycle later; no duplicate transfer; stray wb_ack in IDLE is ignored.
- Reset mid-BUS:
  - Stimulus: assert i_rst=0 during a wait state.
  - Required: cyc/stb fall asynchronously, no ack; the next request after release works normally.
- Timeout (DMEM_BRIDGE_TIMEOUT_EN, TIMEOUT_CYC=8):
  - Stimulus: silent slave.
  - Required: exception+ack after 8 BUS cycles.
  - Boundary: slave ack on cycle 8 gives a normal ack.
